// File: rtl/axis_pixel_generator.sv
// axis_pixel_generator
// Test-pattern video source. It emits frames of packed 24-bit RGB pixels on an
// AXI4-Stream master. tuser marks the first word of a frame and tlast marks the
// last word of a line. A small AXI4-Lite register file configures it.
// Four pixels pack into three 32-bit words: {p3,p2,p1,p0} = {w2,w1,w0}.
//
// Optional build macro: PIXGEN_FRAME_CNT_EN adds the 32-bit frame counter. With
// the macro, FRAME_CNT (0x0C) is readable and gradient blue = frame[7:0].
// Without it, 0x0C reads 0 and gradient blue = 0.
//
// Ports:
//   out_stream_aclk        clock for stream and AXI-Lite logic
//   axi_reset              asynchronous active-high reset
//   out_stream_t*          AXI4-Stream master (tdata/tkeep/tlast/tuser/tvalid/tready)
//   s_axi_lite_aw*/w*/b*   AXI4-Lite write channels
//   s_axi_lite_ar*/r*      AXI4-Lite read channels
// Register map (word addressed):
//   0x00 CTRL[0] enable (resets to 1)
//   0x04 PATTERN[1:0]
//   0x08 COLOR[23:0]
//   0x0C FRAME_CNT (read only)
module axis_pixel_generator #(
  parameter int unsigned X_WORDS = 480,
  parameter int unsigned Y_SIZE  = 480,
  parameter int unsigned ADDR_W  = 8
) (
  input  logic              out_stream_aclk,
  input  logic              axi_reset,
  output logic [31:0]       out_stream_tdata,
  output logic [3:0]        out_stream_tkeep,
  output logic              out_stream_tlast,
  output logic              out_stream_tuser,
  output logic              out_stream_tvalid,
  input  logic              out_stream_tready,
  input  logic [ADDR_W-1:0] s_axi_lite_awaddr,
  input  logic              s_axi_lite_awvalid,
  output logic              s_axi_lite_awready,
  input  logic [31:0]       s_axi_lite_wdata,
  input  logic              s_axi_lite_wvalid,
  output logic              s_axi_lite_wready,
  output logic [1:0]        s_axi_lite_bresp,
  output logic              s_axi_lite_bvalid,
  input  logic              s_axi_lite_bready,
  input  logic [ADDR_W-1:0] s_axi_lite_araddr,
  input  logic              s_axi_lite_arvalid,
  output logic              s_axi_lite_arready,
  output logic [31:0]       s_axi_lite_rdata,
  output logic [1:0]        s_axi_lite_rresp,
  output logic              s_axi_lite_rvalid,
  input  logic              s_axi_lite_rready
);

  localparam int unsigned GROUPS = X_WORDS / 3;
  localparam int unsigned GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int unsigned YW     = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;
  localparam int unsigned AW     = ADDR_W - 2;

  // Position of the next word to load: pixel group, word-in-group, line.
  logic [GW-1:0] grp_q;
  logic [1:0]    sub_q;
  logic [YW-1:0] y_q;

  logic          tvalid_q, tlast_q, tuser_q, eof_q;
  logic [31:0]   tdata_q;

  // Register file and per-frame active copies.
  logic          en_q;
  logic [1:0]    pat_q, pat_act_q;
  logic [23:0]   color_q, color_act_q;

  logic          awready_q, bvalid_q, arready_q, rvalid_q;
  logic [31:0]   rdata_q;

  logic          load_c, sof_c, emit_c, last_word_c, last_line_c, frame_inc_c;
  logic [1:0]    pat_use_c;
  logic [23:0]   color_use_c;
  logic [23:0]   pix_c [4];
  logic [95:0]   grp_bits_c;
  logic [31:0]   word_c, rdata_c, frame_rd_c;
  logic [7:0]    blue_c;
  logic          wr_c, rd_c;
  logic          unused_bits;

  assign unused_bits = ^{s_axi_lite_awaddr[1:0], s_axi_lite_araddr[1:0],
                         s_axi_lite_wdata[31:24]};

  // The output register can take a new word when empty or when its word leaves.
  assign load_c      = !tvalid_q || out_stream_tready;
  assign sof_c       = (grp_q == '0) && (sub_q == 2'd0) && (y_q == '0);
  assign emit_c      = load_c && (!sof_c || en_q);
  assign last_word_c = (grp_q == GW'(GROUPS - 1)) && (sub_q == 2'd2);
  assign last_line_c = (y_q == YW'(Y_SIZE - 1));
  assign frame_inc_c = tvalid_q && out_stream_tready && eof_q;

`ifdef PIXGEN_FRAME_CNT_EN
  logic [31:0] frame_q;
  logic [31:0] frame_nxt_c;

  // The frame count bumps when the final word of a frame transfers.
  always_ff @(posedge out_stream_aclk or posedge axi_reset) begin
    if (axi_reset)        frame_q <= '0;
    else if (frame_inc_c) frame_q <= frame_q + 32'd1;
  end

  // The first word of a new frame may load on the same edge as the bump.
  assign frame_nxt_c = frame_q + 32'(frame_inc_c);
  assign blue_c      = frame_nxt_c[7:0];
  assign frame_rd_c  = frame_q;
`else
  logic unused_frame_inc;
  assign unused_frame_inc = frame_inc_c;
  assign blue_c           = 8'd0;
  assign frame_rd_c       = 32'd0;
`endif

  // Build the pixel group for the next word and select its 32-bit slice.
  always_comb begin
    pat_use_c   = sof_c ? pat_q : pat_act_q;
    color_use_c = sof_c ? color_q : color_act_q;
    pix_c       = '{default: '0};
    for (int i = 0; i < 4; i++) begin
      if (pat_use_c == 2'd1) pix_c[i] = color_use_c;
      else                   pix_c[i] = {8'({grp_q, 2'(i)}), 8'(y_q), blue_c};
    end
    grp_bits_c = {pix_c[3], pix_c[2], pix_c[1], pix_c[0]};
    case (sub_q)
      2'd0:    word_c = grp_bits_c[31:0];
      2'd1:    word_c = grp_bits_c[63:32];
      default: word_c = grp_bits_c[95:64];
    endcase
  end

  // Stream output register and position counters.
  always_ff @(posedge out_stream_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      tuser_q     <= 1'b0;
      eof_q       <= 1'b0;
      tdata_q     <= '0;
      grp_q       <= '0;
      sub_q       <= '0;
      y_q         <= '0;
      pat_act_q   <= '0;
      color_act_q <= '0;
    end else if (load_c) begin
      tvalid_q <= emit_c;
      if (emit_c) begin
        tdata_q <= word_c;
        tlast_q <= last_word_c;
        tuser_q <= sof_c;
        eof_q   <= last_word_c && last_line_c;
        if (sof_c) begin
          pat_act_q   <= pat_q;
          color_act_q <= color_q;
        end
        if (sub_q == 2'd2) begin
          sub_q <= 2'd0;
          if (grp_q == GW'(GROUPS - 1)) begin
            grp_q <= '0;
            y_q   <= last_line_c ? '0 : y_q + YW'(1);
          end else begin
            grp_q <= grp_q + GW'(1);
          end
        end else begin
          sub_q <= sub_q + 2'd1;
        end
      end
    end
  end

  assign wr_c = awready_q && s_axi_lite_awvalid && s_axi_lite_wvalid;
  assign rd_c = arready_q && s_axi_lite_arvalid;

  always_comb begin
    rdata_c = 32'd0;
    case (s_axi_lite_araddr[ADDR_W-1:2])
      AW'(0):  rdata_c = {31'd0, en_q};
      AW'(1):  rdata_c = {30'd0, pat_q};
      AW'(2):  rdata_c = {8'd0, color_q};
      AW'(3):  rdata_c = frame_rd_c;
      default: rdata_c = 32'd0;
    endcase
  end

  // AXI-Lite slave: single-cycle ready pulses, responses held until accepted.
  always_ff @(posedge out_stream_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      en_q      <= 1'b1;
      pat_q     <= '0;
      color_q   <= '0;
    end else begin
      awready_q <= s_axi_lite_awvalid && s_axi_lite_wvalid && !bvalid_q && !awready_q;
      arready_q <= s_axi_lite_arvalid && !rvalid_q && !arready_q;
      if (bvalid_q && s_axi_lite_bready) bvalid_q <= 1'b0;
      if (rvalid_q && s_axi_lite_rready) rvalid_q <= 1'b0;
      if (wr_c) begin
        bvalid_q <= 1'b1;
        case (s_axi_lite_awaddr[ADDR_W-1:2])
          AW'(0):  en_q    <= s_axi_lite_wdata[0];
          AW'(1):  pat_q   <= s_axi_lite_wdata[1:0];
          AW'(2):  color_q <= s_axi_lite_wdata[23:0];
          default: ;
        endcase
      end
      if (rd_c) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rdata_c;
      end
    end
  end

  assign out_stream_tdata   = tdata_q;
  assign out_stream_tkeep   = 4'hF;
  assign out_stream_tlast   = tlast_q;
  assign out_stream_tuser   = tuser_q;
  assign out_stream_tvalid  = tvalid_q;
  assign s_axi_lite_awready = awready_q;
  assign s_axi_lite_wready  = awready_q;
  assign s_axi_lite_bresp   = 2'b00;
  assign s_axi_lite_bvalid  = bvalid_q;
  assign s_axi_lite_arready = arready_q;
  assign s_axi_lite_rdata   = rdata_q;
  assign s_axi_lite_rresp   = 2'b00;
  assign s_axi_lite_rvalid  = rvalid_q;

endmodule

// File: tb/tb_axis_pixel_generator.sv
// Randomised bench for axis_pixel_generator on a reduced 12-word x 4-line frame.
// A pixel/frame model derived from the packing rules predicts every stream word.
module tb_axis_pixel_generator;

  localparam int X_WORDS = 12;
  localparam int Y_SIZE  = 4;
`ifdef PIXGEN_FRAME_CNT_EN
  localparam bit FCE = 1'b1;
`else
  localparam bit FCE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tlast, tuser, tvalid, tready;
  logic [7:0]  awaddr, araddr;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [31:0] wdata, rdata;
  logic [1:0]  bresp, rresp;
  logic        arvalid, arready, rvalid, rready;

  always #5 clk = ~clk;

  axis_pixel_generator #(.X_WORDS(X_WORDS), .Y_SIZE(Y_SIZE), .ADDR_W(8)) dut (
    .out_stream_aclk(clk), .axi_reset(rst),
    .out_stream_tdata(tdata), .out_stream_tkeep(tkeep), .out_stream_tlast(tlast),
    .out_stream_tuser(tuser), .out_stream_tvalid(tvalid), .out_stream_tready(tready),
    .s_axi_lite_awaddr(awaddr), .s_axi_lite_awvalid(awvalid), .s_axi_lite_awready(awready),
    .s_axi_lite_wdata(wdata), .s_axi_lite_wvalid(wvalid), .s_axi_lite_wready(wready),
    .s_axi_lite_bresp(bresp), .s_axi_lite_bvalid(bvalid), .s_axi_lite_bready(bready),
    .s_axi_lite_araddr(araddr), .s_axi_lite_arvalid(arvalid), .s_axi_lite_arready(arready),
    .s_axi_lite_rdata(rdata), .s_axi_lite_rresp(rresp), .s_axi_lite_rvalid(rvalid),
    .s_axi_lite_rready(rready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Reference model state.
  int          mx, my;
  int unsigned mframe;
  int          act_pat, sh_pat;
  logic [23:0] act_col, sh_col;
  bit          sh_en;
  bit          in_reset = 1'b1;
  bit          ready_rand = 1'b0;
  int          gap;
  bit          stall_prev;
  logic [31:0] st_data;
  logic        st_last, st_user;

  function automatic void model_reset();
    mx = 0; my = 0; mframe = 0;
    sh_en = 1'b1; sh_pat = 0; sh_col = '0;
    act_pat = 0; act_col = '0;
    gap = 0; stall_prev = 1'b0;
  endfunction

  // Word xw of line yy: four 24-bit pixels laid into 96 bits, slice xw%3.
  function automatic logic [31:0] exp_word(input int xw, input int yy, input logic [7:0] bval,
                                           input int pat, input logic [23:0] col);
    logic [95:0] g;
    logic [23:0] p;
    int          x;
    g = '0;
    for (int i = 0; i < 4; i++) begin
      x = (xw / 3) * 4 + i;
      if (pat == 1) p = col;
      else          p = {x[7:0], yy[7:0], bval};
      g[24*i +: 24] = p;
    end
    return g[32*(xw % 3) +: 32];
  endfunction

  // Stream monitor: picks tready, then checks the word that the next edge transfers.
  always @(negedge clk) begin
    logic [7:0] bval;
    if (!in_reset) begin
      tready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (mx == 0 && my == 0 && !sh_en) check_eq("idle_tvalid", 32'(tvalid), 32'd0);
      if (stall_prev) begin
        check_eq("stall_tvalid", 32'(tvalid), 32'd1);
        check_eq("stall_tdata", tdata, st_data);
        check_eq("stall_tlast", 32'(tlast), 32'(st_last));
        check_eq("stall_tuser", 32'(tuser), 32'(st_user));
      end
      stall_prev = 1'b0;
      if (tvalid) begin
        gap = 0;
        if (tready) begin
          if (mx == 0 && my == 0) begin
            act_pat = sh_pat;
            act_col = sh_col;
          end
          bval = FCE ? mframe[7:0] : 8'd0;
          check_eq("tdata", tdata, exp_word(mx, my, bval, act_pat, act_col));
          check_eq("tlast", 32'(tlast), 32'(mx == X_WORDS - 1));
          check_eq("tuser", 32'(tuser), 32'(mx == 0 && my == 0));
          mx++;
          if (mx == X_WORDS) begin
            mx = 0; my++;
            if (my == Y_SIZE) begin my = 0; mframe++; end
          end
        end else begin
          stall_prev = 1'b1;
          st_data = tdata; st_last = tlast; st_user = tuser;
        end
      end else if (mx != 0 || my != 0) begin
        gap++;
        check_eq("gap_le8", 32'(gap <= 8), 32'd1);
      end
    end
  end

  task automatic axi_write(input logic [7:0] a, input logic [31:0] d);
    bit ok;
    @(negedge clk);
    awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 16 && !ok; n++) begin
      if (awready && wready) ok = 1'b1;
      else @(negedge clk);
    end
    check_eq("aw_handshake", 32'(ok), 32'd1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    case (a[7:2])
      6'd0: sh_en  = d[0];
      6'd1: sh_pat = int'(d[1:0]);
      6'd2: sh_col = d[23:0];
      default: ;
    endcase
    ok = 1'b0;
    for (int n = 0; n < 16 && !ok; n++) begin
      @(negedge clk);
      if (bvalid) ok = 1'b1;
    end
    check_eq("bvalid_rise", 32'(ok), 32'd1);
    check_eq("bresp", 32'(bresp), 32'd0);
    @(negedge clk);
    check_eq("bvalid_hold", 32'(bvalid), 32'd1);
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    check_eq("bvalid_clear", 32'(bvalid), 32'd0);
  endtask

  task automatic axi_read(input logic [7:0] a, input logic [31:0] exp, input string tag);
    bit          ok;
    logic [31:0] first;
    @(negedge clk);
    araddr = a; arvalid = 1'b1; rready = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 16 && !ok; n++) begin
      if (arready) ok = 1'b1;
      else @(negedge clk);
    end
    check_eq("ar_handshake", 32'(ok), 32'd1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 16 && !ok; n++) begin
      @(negedge clk);
      if (rvalid) ok = 1'b1;
    end
    check_eq("rvalid_rise", 32'(ok), 32'd1);
    check_eq(tag, rdata, exp);
    check_eq("rresp", 32'(rresp), 32'd0);
    first = rdata;
    @(negedge clk);
    check_eq("rvalid_hold", 32'(rvalid), 32'd1);
    check_eq("rdata_hold", rdata, first);
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    check_eq("rvalid_clear", 32'(rvalid), 32'd0);
  endtask

  task automatic wait_frames(input int unsigned target);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 4000 && !ok; n++) begin
      @(negedge clk);
      if (mframe >= target) ok = 1'b1;
    end
    check_eq("frame_reached", 32'(ok), 32'd1);
  endtask

  task automatic wait_pos(input int yy, input int xx);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 4000 && !ok; n++) begin
      @(negedge clk);
      if (my == yy && mx == xx) ok = 1'b1;
    end
    check_eq("pos_reached", 32'(ok), 32'd1);
  endtask

  task automatic release_reset();
    bit seen;
    @(negedge clk); #2;
    rst = 1'b0;
    in_reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      @(posedge clk); #1;
      seen = tvalid;
    end
    check_eq("tvalid_rise", 32'(seen), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int unsigned f0;
    rst = 1'b1; tready = 1'b0;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_tvalid", 32'(tvalid), 32'd0);
    check_eq("rst_tlast", 32'(tlast), 32'd0);
    check_eq("rst_tuser", 32'(tuser), 32'd0);
    check_eq("rst_tdata", tdata, 32'd0);
    check_eq("tkeep", 32'(tkeep), 32'hF);
    check_eq("rst_awready", 32'(awready), 32'd0);
    check_eq("rst_wready", 32'(wready), 32'd0);
    check_eq("rst_bvalid", 32'(bvalid), 32'd0);
    check_eq("rst_arready", 32'(arready), 32'd0);
    check_eq("rst_rvalid", 32'(rvalid), 32'd0);
    check_eq("rst_resp", 32'({bresp, rresp}), 32'd0);
    release_reset();

    // Always-ready sink, default gradient, two frames.
    wait_frames(2);

    // Random backpressure; pattern change mid-frame applies from the next frame.
    ready_rand = 1'b1;
    wait_pos(1, 0);
    axi_read(8'h0C, FCE ? 32'(mframe) : 32'd0, "rd_frame_cnt");
    axi_write(8'h04, 32'h0000_0001);
    axi_write(8'h08, 32'h00AB_CDEF);
    f0 = mframe;
    axi_read(8'h00, 32'd1, "rd_ctrl");
    axi_read(8'h04, 32'd1, "rd_pattern");
    axi_read(8'h09, 32'h00AB_CDEF, "rd_color");
    axi_read(8'h10, 32'd0, "rd_unmapped");
    wait_frames(f0 + 2);

    // Unlisted pattern value falls back to gradient; then disable / re-enable.
    wait_pos(1, 0);
    axi_write(8'h04, 32'h0000_0002);
    axi_write(8'h00, 32'h0000_0000);
    f0 = mframe;
    wait_frames(f0 + 1);
    repeat (20) @(negedge clk);
    axi_write(8'h14, 32'hFFFF_FFFF);
    axi_read(8'h14, 32'd0, "rd_unmapped_wr");
    axi_read(8'h00, 32'd0, "rd_ctrl_off");
    axi_write(8'h00, 32'h0000_0001);
    wait_frames(f0 + 2);

    // Asynchronous reset mid-line aborts the frame.
    wait_pos(1, 5);
    in_reset = 1'b1;
    #2 rst = 1'b1;
    #1;
    check_eq("async_rst_tvalid", 32'(tvalid), 32'd0);
    check_eq("async_rst_tuser", 32'(tuser), 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    release_reset();
    axi_read(8'h0C, 32'd0, "rd_frame_cnt_rst");
    axi_read(8'h04, 32'd0, "rd_pattern_rst");
    wait_frames(1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
